// File: rtl/hpi_bus_master.sv
// hpi_bus_master: turns single-beat software requests into timed host-port
// cycles (chip select, address, read/write strobe, tristate data bus).
// It also synchronises the host interrupt and gives a level and a rising-edge pulse.
module hpi_bus_master #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 2,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int INT_ACT_HI = 1
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              irq_level,
  output logic              irq_pulse,
  inout  wire  [DATA_W-1:0] OTG_DATA,
  output logic [ADDR_W-1:0] OTG_ADDR,
  output logic              OTG_RD_N,
  output logic              OTG_WR_N,
  output logic              OTG_CS_N,
  output logic              OTG_RST_N,
  input  logic              OTG_INT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // The phase counter is loaded with (cycles - 1) and counts down to zero.
  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);
  localparam logic       INT_INVERT  = (INT_ACT_HI == 0) ? 1'b1 : 1'b0;

  state_t            state;
  state_t            state_next;
  logic [3:0]        phase_cnt;
  logic [3:0]        phase_cnt_next;
  logic              accept;
  logic              write_next;
  logic              lat_write;
  logic [DATA_W-1:0] lat_wdata;
  logic              data_oe;
  logic              int_sync1;
  logic              int_sync2;

  // OTG_RST_N doubles as the "out of reset" flag, so ready rises on the first edge.
  assign req_ready  = (state == IDLE) && OTG_RST_N;
  assign accept     = req_valid && req_ready;
  assign write_next = accept ? req_write : lat_write;
  assign OTG_DATA   = data_oe ? lat_wdata : {DATA_W{1'bz}};
  assign irq_level  = int_sync2;

  // Next-state and phase-counter logic for the bus cycle sequencer.
  always_comb begin
    state_next     = state;
    phase_cnt_next = phase_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next     = SETUP;
          phase_cnt_next = SETUP_LOAD;
        end else begin
          state_next     = IDLE;
          phase_cnt_next = 4'd0;
        end
      end
      SETUP: begin
        if (phase_cnt == 4'd0) begin
          state_next     = STROBE;
          phase_cnt_next = STROBE_LOAD;
        end else begin
          phase_cnt_next = phase_cnt - 4'd1;
        end
      end
      STROBE: begin
        if (phase_cnt == 4'd0) begin
          state_next     = HOLD;
          phase_cnt_next = HOLD_LOAD;
        end else begin
          phase_cnt_next = phase_cnt - 4'd1;
        end
      end
      HOLD: begin
        if (phase_cnt == 4'd0) begin
          state_next     = IDLE;
          phase_cnt_next = 4'd0;
        end else begin
          phase_cnt_next = phase_cnt - 4'd1;
        end
      end
      default: begin
        state_next     = IDLE;
        phase_cnt_next = 4'd0;
      end
    endcase
  end

  // Sequencer state and phase counter registers.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state     <= IDLE;
      phase_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      phase_cnt <= phase_cnt_next;
    end
  end

  // Capture the request on acceptance so later input changes cannot disturb it.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      lat_write <= 1'b0;
      lat_wdata <= '0;
      OTG_ADDR  <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_wdata <= req_wdata;
      OTG_ADDR  <= req_addr;
    end
  end

  // Host strobes and data enable are registered from the next state, so they
  // line up with the state they belong to without any combinational path.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      OTG_CS_N <= 1'b1;
      OTG_RD_N <= 1'b1;
      OTG_WR_N <= 1'b1;
      data_oe  <= 1'b0;
    end else begin
      OTG_CS_N <= (state_next == IDLE);
      OTG_RD_N <= !((state_next == STROBE) && !lat_write);
      OTG_WR_N <= !((state_next == STROBE) && lat_write);
      data_oe  <= (state_next != IDLE) && write_next;
    end
  end

  // Completion pulse and read-data capture at the end of the last strobe cycle.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state == HOLD) && (phase_cnt == 4'd0);
      if ((state == STROBE) && (phase_cnt == 4'd0) && !lat_write) begin
        rsp_rdata <= OTG_DATA;
      end
    end
  end

  // Host reset is held while Reset_N is low and released on the first edge after.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      OTG_RST_N <= 1'b0;
    end else begin
      OTG_RST_N <= 1'b1;
    end
  end

  // Two-flop interrupt synchroniser in normalised (active-high) polarity plus edge pulse.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      int_sync1 <= 1'b0;
      int_sync2 <= 1'b0;
      irq_pulse <= 1'b0;
    end else begin
      int_sync1 <= OTG_INT ^ INT_INVERT;
      int_sync2 <= int_sync1;
      irq_pulse <= int_sync1 && !int_sync2;
    end
  end

endmodule

// File: tb/tb_hpi_bus_master.sv
// Bench for hpi_bus_master: a default instance and a slow 32-bit active-low
// interrupt instance, each compared every cycle against a transaction-timeline model.
module tb_hpi_bus_master;

  localparam int S0 = 1, T0 = 2, H0 = 1;
  localparam int S1 = 3, T1 = 4, H1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_valid, req_write, otg_int;
  logic [1:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  wire  [1:0]  req_ready, rsp_valid, irq_level, irq_pulse, rd_n, wr_n, cs_n, hrst_n;
  wire  [15:0] rdata0, bus0;
  wire  [31:0] rdata1, bus1;
  wire  [1:0]  haddr0, haddr1;
  logic [1:0]  drv_en;
  logic [31:0] drv_val [2];

  assign bus0 = drv_en[0] ? drv_val[0][15:0] : 16'hzzzz;
  assign bus1 = drv_en[1] ? drv_val[1] : 32'hzzzzzzzz;

  hpi_bus_master dut0 (
    .Clk(clk), .Reset_N(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0][15:0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rdata0),
    .irq_level(irq_level[0]), .irq_pulse(irq_pulse[0]),
    .OTG_DATA(bus0), .OTG_ADDR(haddr0), .OTG_RD_N(rd_n[0]), .OTG_WR_N(wr_n[0]),
    .OTG_CS_N(cs_n[0]), .OTG_RST_N(hrst_n[0]), .OTG_INT(otg_int[0])
  );

  hpi_bus_master #(
    .DATA_W(32), .ADDR_W(2), .SETUP_CYC(S1), .STROBE_CYC(T1), .HOLD_CYC(H1), .INT_ACT_HI(0)
  ) dut1 (
    .Clk(clk), .Reset_N(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rdata1),
    .irq_level(irq_level[1]), .irq_pulse(irq_pulse[1]),
    .OTG_DATA(bus1), .OTG_ADDR(haddr1), .OTG_RD_N(rd_n[1]), .OTG_WR_N(wr_n[1]),
    .OTG_CS_N(cs_n[1]), .OTG_RST_N(hrst_n[1]), .OTG_INT(otg_int[1])
  );

  // ---------------- model: one in-flight transaction per instance ----------------
  bit          oor;                 // out of reset
  bit          busy  [2];           // a transaction occupies the bus
  int          el    [2];           // cycles elapsed since the accept edge (1 = first)
  bit          m_wr  [2];
  logic [1:0]  m_addr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  bit          m_rsp [2];
  bit          ih1 [2], ih2 [2], ih3 [2];   // normalised interrupt seen 1, 2, 3 edges ago

  int checks = 0;
  int passes = 0;

  function automatic int s_of(input int d); return (d == 0) ? S0 : S1; endfunction
  function automatic int t_of(input int d); return (d == 0) ? T0 : T1; endfunction
  function automatic int l_of(input int d);
    return (d == 0) ? (S0 + T0 + H0) : (S1 + T1 + H1);
  endfunction
  function automatic logic [31:0] mask_of(input int d);
    return (d == 0) ? 32'h0000FFFF : 32'hFFFFFFFF;
  endfunction
  function automatic logic [31:0] bus_of(input int d);
    return (d == 0) ? {16'h0000, bus0} : bus1;
  endfunction
  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? {16'h0000, rdata0} : rdata1;
  endfunction
  function automatic logic [31:0] addr_of(input int d);
    return (d == 0) ? {30'd0, haddr0} : {30'd0, haddr1};
  endfunction

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL dut%0d %s: got %h, expected %h at t=%0t", d, name, act, exp, $time);
  endtask

  task automatic model_reset();
    oor = 1'b0;
    for (int d = 0; d < 2; d++) begin
      busy[d] = 1'b0; el[d] = 0; m_wr[d] = 1'b0; m_addr[d] = 2'd0;
      m_wdata[d] = 32'd0; m_rdata[d] = 32'd0; m_rsp[d] = 1'b0;
      ih1[d] = 1'b0; ih2[d] = 1'b0; ih3[d] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge using the inputs the DUT just sampled.
  task automatic model_edge();
    bit rdy_prev;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        rdy_prev = oor && !busy[d];
        if (busy[d] && !m_wr[d] && el[d] == s_of(d) + t_of(d))
          m_rdata[d] = drv_val[d] & mask_of(d);
        m_rsp[d] = 1'b0;
        if (busy[d]) begin
          if (el[d] == l_of(d)) begin busy[d] = 1'b0; m_rsp[d] = 1'b1; end
          else el[d] = el[d] + 1;
        end
        if (rdy_prev && req_valid[d]) begin
          busy[d] = 1'b1; el[d] = 1; m_wr[d] = req_write[d];
          m_addr[d] = req_addr[d]; m_wdata[d] = req_wdata[d] & mask_of(d);
        end
        ih3[d] = ih2[d];
        ih2[d] = ih1[d];
        ih1[d] = (d == 0) ? otg_int[0] : !otg_int[1];
      end
      oor = 1'b1;
    end
  endtask

  // The bench drives the bus whenever the DUT is not expected to.
  task automatic apply_drive();
    for (int d = 0; d < 2; d++) drv_en[d] = !(busy[d] && m_wr[d]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    apply_drive();
    @(negedge clk);
    #1;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit strb;
      strb = busy[d] && (el[d] > s_of(d)) && (el[d] <= s_of(d) + t_of(d));
      chk(d, "cs_n", 32'(cs_n[d]), 32'(!busy[d]));
      chk(d, "rd_n", 32'(rd_n[d]), 32'(!(strb && !m_wr[d])));
      chk(d, "wr_n", 32'(wr_n[d]), 32'(!(strb && m_wr[d])));
      chk(d, "strobe_excl", 32'(rd_n[d] | wr_n[d]), 32'd1);
      chk(d, "otg_addr", addr_of(d), 32'(m_addr[d]));
      chk(d, "req_ready", 32'(req_ready[d]), 32'(oor && !busy[d]));
      chk(d, "rsp_valid", 32'(rsp_valid[d]), 32'(m_rsp[d]));
      chk(d, "rsp_rdata", rdata_of(d), m_rdata[d]);
      chk(d, "otg_rst_n", 32'(hrst_n[d]), 32'(oor));
      chk(d, "otg_data", bus_of(d), (busy[d] && m_wr[d]) ? m_wdata[d] : (drv_val[d] & mask_of(d)));
      chk(d, "irq_level", 32'(irq_level[d]), 32'(ih2[d]));
      chk(d, "irq_pulse", 32'(irq_pulse[d]), 32'(ih2[d] && !ih3[d]));
    end
  end

  // Walk one transaction from the cycle after its accept edge up to its rsp_valid cycle.
  task automatic measure(input int d, input bit wr, input int exp_cs, input int exp_first,
                         input int exp_cnt, input int exp_edges, output logic [31:0] data);
    int c, cs_cnt, st_cnt, st_first, other_cnt, rsp_c;
    c = 1; cs_cnt = 0; st_cnt = 0; st_first = 0; other_cnt = 0; rsp_c = 0; data = 32'd0;
    while (c <= 20 && rsp_c == 0) begin
      if (!cs_n[d]) cs_cnt++;
      if (wr ? !wr_n[d] : !rd_n[d]) begin
        st_cnt++;
        if (st_first == 0) st_first = c;
      end
      if (wr ? !rd_n[d] : !wr_n[d]) other_cnt++;
      if (rsp_valid[d]) begin
        rsp_c = c;
        data = rdata_of(d);
      end else begin
        tick();
        c++;
      end
    end
    chk(d, "cs_low_cycles", cs_cnt, exp_cs);
    chk(d, "strobe_first_cycle", st_first, exp_first);
    chk(d, "strobe_low_cycles", st_cnt, exp_cnt);
    chk(d, "wrong_strobe_cycles", other_cnt, 32'd0);
    chk(d, "rsp_edge_after_accept", rsp_c - 1, exp_edges);
  endtask

  task automatic issue(input int d, input bit wr, input logic [1:0] a, input logic [31:0] wd);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd;
    tick();
    // scramble the inputs: the transaction in flight must not notice
    req_valid[d] = 1'b0; req_write[d] = !wr; req_addr[d] = ~a; req_wdata[d] = ~wd;
  endtask

  initial begin
    logic [31:0] data;
    int n, pc0, pc1, pf0, pf1;
    rst_n = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; otg_int = 2'b10;
    for (int d = 0; d < 2; d++) begin req_addr[d] = 2'd0; req_wdata[d] = 32'd0; end
    drv_val[0] = 32'h0000A5A5; drv_val[1] = 32'h5A5A5A5A;
    model_reset();
    apply_drive();
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "reset_ready", 32'(req_ready[d]), 32'd0);
      chk(d, "reset_hrst_n", 32'(hrst_n[d]), 32'd0);
      chk(d, "reset_cs_n", 32'(cs_n[d]), 32'd1);
      chk(d, "reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk(d, "reset_rdata", rdata_of(d), 32'd0);
    end
    repeat (2) tick();
    #1 rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk(d, "release_ready", 32'(req_ready[d]), 32'd1);
      chk(d, "release_hrst_n", 32'(hrst_n[d]), 32'd1);
    end

    // default write: addr 2, BEEF
    issue(0, 1'b1, 2'd2, 32'h0000BEEF);
    measure(0, 1'b1, 4, 2, 2, 4, data);
    tick();

    // default read: bench returns 1234
    drv_val[0] = 32'h00001234;
    issue(0, 1'b0, 2'd1, 32'h00000000);
    measure(0, 1'b0, 4, 2, 2, 4, data);
    chk(0, "read_data", data, 32'h00001234);
    tick();
    chk(0, "read_data_held", rdata_of(0), 32'h00001234);

    // back-to-back: write then read with req_valid held high
    drv_val[0] = 32'h00005AA5;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 2'd3; req_wdata[0] = 32'h0000C0DE;
    tick();
    req_write[0] = 1'b0; req_addr[0] = 2'd0; req_wdata[0] = 32'd0;
    n = 0;
    while (!rsp_valid[0] && n < 10) begin tick(); n++; end
    chk(0, "b2b_first_rsp_edge", n, 32'd4);
    chk(0, "b2b_write_keeps_rdata", rdata_of(0), 32'h00001234);
    tick();
    req_valid[0] = 1'b0;
    chk(0, "b2b_cs_follows_rsp", 32'(cs_n[0]), 32'd0);
    n = 0;
    while (!rsp_valid[0] && n < 10) begin tick(); n++; end
    chk(0, "b2b_second_rsp_edge", n, 32'd4);
    chk(0, "b2b_read_data", rdata_of(0), 32'h00005AA5);
    tick();

    // non-default timing, 32-bit bus
    issue(1, 1'b1, 2'd1, 32'hDEADBEEF);
    measure(1, 1'b1, 9, 4, 4, 9, data);
    tick();
    drv_val[1] = 32'hCAFEF00D;
    issue(1, 1'b0, 2'd3, 32'h00000000);
    measure(1, 1'b0, 9, 4, 4, 9, data);
    chk(1, "read_data", data, 32'hCAFEF00D);
    tick();

    // interrupts: short asynchronous pulse, then a held assertion
    #2 otg_int = 2'b01;
    tick();
    #2 otg_int = 2'b10;
    repeat (5) tick();
    #2 otg_int = 2'b01;
    pc0 = 0; pc1 = 0; pf0 = 0; pf1 = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (irq_pulse[0]) begin pc0++; if (pf0 == 0) pf0 = c; end
      if (irq_pulse[1]) begin pc1++; if (pf1 == 0) pf1 = c; end
    end
    chk(0, "irq_pulse_count", pc0, 32'd1);
    chk(1, "irq_pulse_count", pc1, 32'd1);
    chk(0, "irq_latency_2to3", 32'(pf0 >= 2 && pf0 <= 3), 32'd1);
    chk(1, "irq_latency_2to3", 32'(pf1 >= 2 && pf1 <= 3), 32'd1);
    chk(0, "irq_level_held", 32'(irq_level[0]), 32'd1);
    chk(1, "irq_level_held", 32'(irq_level[1]), 32'd1);
    #2 otg_int = 2'b10;
    repeat (4) tick();
    chk(0, "irq_level_clear", 32'(irq_level[0]), 32'd0);
    chk(1, "irq_level_clear", 32'(irq_level[1]), 32'd0);

    // reset mid-transaction: dut0 write and dut1 read both in STROBE
    drv_val[1] = 32'h13579BDF;
    issue(1, 1'b0, 2'd2, 32'h00000000);
    tick();
    drv_val[0] = 32'h00005AA5;
    issue(0, 1'b1, 2'd1, 32'h00000F0F);
    tick();
    chk(0, "pre_reset_wr_low", 32'(wr_n[0]), 32'd0);
    chk(1, "pre_reset_rd_low", 32'(rd_n[1]), 32'd0);
    #2 rst_n = 1'b0;
    model_reset();
    apply_drive();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_mid_cs_n", 32'(cs_n[d]), 32'd1);
      chk(d, "rst_mid_rd_n", 32'(rd_n[d]), 32'd1);
      chk(d, "rst_mid_wr_n", 32'(wr_n[d]), 32'd1);
      chk(d, "rst_mid_bus_released", bus_of(d), drv_val[d] & mask_of(d));
      chk(d, "rst_mid_ready", 32'(req_ready[d]), 32'd0);
    end
    repeat (2) tick();
    #1 rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_mid_release_ready", 32'(req_ready[d]), 32'd1);
      chk(d, "rst_mid_release_hrst_n", 32'(hrst_n[d]), 32'd1);
    end
    repeat (12) tick();

    // normal operation after the abandoned transaction
    issue(0, 1'b1, 2'd2, 32'h00003C3C);
    measure(0, 1'b1, 4, 2, 2, 4, data);
    repeat (2) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hpi_bus_master.md
HPI_BUS_MASTER -- requirements
Module: hpi_bus_master

Interface
REQ-001 SHALL have parameter DATA_W, default 16: host data bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 2: host address width in bits.
REQ-003 SHALL have parameter SETUP_CYC, default 1: cycles from CS_N assertion to strobe assertion; legal range 1..15.
REQ-004 SHALL have parameter STROBE_CYC, default 2: cycles that RD_N/WR_N are held low; legal range 1..15.
REQ-005 SHALL have parameter HOLD_CYC, default 1: cycles from strobe release to CS_N release; legal range 1..15.
REQ-006 SHALL have parameter INT_ACT_HI, default 1: 1 = OTG_INT active high, 0 = active low.
REQ-007 SHALL have the following ports, listed as name  direction  width  meaning:
Clk  in  1  sole clock; all state changes on its rising edge.
Reset_N  in  1  asynchronous, active-low reset.
req_valid  in  1  software requests a bus transaction.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  transaction address.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  one-cycle completion pulse, for both reads and writes.
rsp_rdata  out  DATA_W  read data, valid while rsp_valid is high after a read.
irq_level  out  1  synchronised interrupt, active-high regardless of polarity.
irq_pulse  out  1  one-cycle pulse on each assertion of irq_level.
OTG_DATA  inout  DATA_W  tristate host data bus.
OTG_ADDR  out  ADDR_W  host address.
OTG_RD_N, OTG_WR_N, OTG_CS_N  out  1 each  active-low host strobes.
OTG_RST_N  out  1  active-low host reset.
OTG_INT  in  1  asynchronous host interrupt.

Function
REQ-008 SHALL implement an FSM with states IDLE, SETUP, STROBE and HOLD, plus one 4-bit phase counter.
REQ-009 SHALL drive req_ready high only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both high.
REQ-010 SHALL register req_write, req_addr and req_wdata on acceptance; later changes to the inputs SHALL NOT affect the transaction in flight.
REQ-011 SHALL move IDLE->SETUP on acceptance and drive OTG_CS_N=0 and OTG_ADDR=latched address for exactly SETUP_CYC cycles.
REQ-012 SHALL move SETUP->STROBE and drive OTG_RD_N=0 (read) or OTG_WR_N=0 (write) for exactly STROBE_CYC cycles, with OTG_CS_N still 0.
REQ-013 SHALL, on a read, capture OTG_DATA into rsp_rdata at the rising edge that ends the last STROBE cycle.
REQ-014 SHALL move STROBE->HOLD with both strobes high and OTG_CS_N=0 and OTG_ADDR held for exactly HOLD_CYC cycles, then return to IDLE.
REQ-015 SHALL assert rsp_valid for exactly the first IDLE cycle after HOLD, so completion comes SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after the accept edge (4 at defaults).
REQ-016 SHALL hold rsp_rdata unchanged until the next read capture; a write SHALL NOT modify rsp_rdata.
REQ-017 SHALL allow back-to-back operation: a request accepted in the same cycle rsp_valid is high enters SETUP on that edge.
REQ-018 SHALL drive OTG_DATA with the latched write data only during SETUP, STROBE and HOLD of a write, and SHALL drive OTG_DATA to high impedance at all other times.
REQ-019 SHALL drive OTG_ADDR, OTG_RD_N, OTG_WR_N and OTG_CS_N from flip-flops, with no combinational path from any req_* input to them.
REQ-020 SHALL never assert OTG_RD_N and OTG_WR_N low at the same time.
REQ-021 SHALL pass OTG_INT through two synchroniser flops, invert it if INT_ACT_HI=0, and present the result as irq_level.
REQ-022 SHALL drive irq_pulse high for one cycle when irq_level goes 0->1; an interrupt held asserted SHALL produce only one pulse.
REQ-023 SHALL treat interrupt activity and bus transactions as fully independent.

Reset
REQ-024 SHALL, while Reset_N=0 and without waiting for a clock edge, force the following: FSM=IDLE, counter=0, OTG_CS_N=OTG_RD_N=OTG_WR_N=1, OTG_ADDR=0, OTG_DATA=high impedance, OTG_RST_N=0, rsp_valid=0, rsp_rdata=0, irq_level=0, irq_pulse=0, synchroniser flops=inactive, req_ready=0.
REQ-025 SHALL drive OTG_RST_N=1 and req_ready=1 from the first rising edge after Reset_N deasserts.
REQ-026 SHALL, if reset is asserted mid-transaction, abandon the transaction immediately with no rsp_valid, and the transaction SHALL NOT resume after reset.

Verification
REQ-027 SHALL cover a default write: req_addr=2, req_wdata=16'hBEEF -> CS_N low 4 cycles, WR_N low exactly cycles 2-3, OTG_DATA=BEEF throughout, rsp_valid at the 4th edge after accept.
REQ-028 SHALL cover a default read: model drives 16'h1234 during STROBE -> RD_N low 2 cycles, OTG_DATA high impedance by the bench's check, rsp_rdata=16'h1234 with rsp_valid.
REQ-029 SHALL cover back-to-back transfers: req_valid held high with write then read -> second CS_N period directly follows the first rsp_valid with zero idle cycles, and the strobes never overlap.
REQ-030 SHALL cover non-default timing: SETUP_CYC=3, STROBE_CYC=4, HOLD_CYC=2, DATA_W=32 -> strobe low exactly 4 cycles, rsp_valid 9 cycles after accept.
REQ-031 SHALL cover interrupts: OTG_INT pulsed asynchronously, then held high for 10 cycles -> exactly one irq_pulse, 2-3 cycles after the edge; with INT_ACT_HI=0, a low level produces the pulse.
REQ-032 SHALL cover reset mid-transaction: Reset_N low during STROBE -> strobes/CS_N high and bus high impedance before the next edge, no rsp_valid, and OTG_RST_N high plus req_ready high one edge after release.
